// File: rtl/cello_tt_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : cello_tt_eval_if
// Purpose  : Stream and configuration bundle for the cello_tt_eval
//            truth-table evaluator.
// Signals  : in_vec/in_valid/in_ready   - input index stream
//            out/out_valid/out_ready    - evaluated result stream
//            cfg_start/cfg_bit/cfg_valid - serial table reload (MSB first)
//            cfg_done                   - new table active (1-cycle pulse)
//            busy                       - evaluator is not idle
// Modports : master - stimulus side (drives inputs, consumes results)
//            slave  - evaluator side
// Revision : 1.0 - initial release
// ============================================================================
interface cello_tt_eval_if #(
  parameter int N_IN = 4
) ();

  logic [N_IN-1:0] in_vec;
  logic            in_valid;
  logic            in_ready;
  logic            out;
  logic            out_valid;
  logic            out_ready;
  logic            cfg_start;
  logic            cfg_bit;
  logic            cfg_valid;
  logic            cfg_done;
  logic            busy;

  modport master (
    output in_vec, in_valid, out_ready, cfg_start, cfg_bit, cfg_valid,
    input  in_ready, out, out_valid, cfg_done, busy
  );

  modport slave (
    input  in_vec, in_valid, out_ready, cfg_start, cfg_bit, cfg_valid,
    output in_ready, out, out_valid, cfg_done, busy
  );

endinterface
`default_nettype wire

// File: rtl/cello_tt_eval.sv
`default_nettype none
// ============================================================================
// Module   : cello_tt_eval
// Purpose  : Evaluates an N_IN-input Boolean function held in a run-time
//            reprogrammable truth table. Indices enter on a valid/ready
//            stream, pass a 2-stage pipeline and leave as a 1-bit result
//            stream. The table is reloaded serially, MSB first.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            bus        - cello_tt_eval_if.slave (streams + config port)
//            eval_count - 16-bit saturating result-handshake counter
//                         (only when CELLO_TT_EVAL_COUNT_EN is defined)
// Options  : CELLO_TT_EVAL_COUNT_EN - adds the eval_count port and counter
// Revision : 1.0 - initial release
// ============================================================================
module cello_tt_eval #(
  parameter int                      N_IN    = 4,
  parameter logic [(2**N_IN)-1:0]    TT_INIT = 16'h599A
) (
  input  logic             clk,
  input  logic             rst_n,
  cello_tt_eval_if.slave   bus
`ifdef CELLO_TT_EVAL_COUNT_EN
  ,
  output logic [15:0]      eval_count
`endif
);

  localparam int                 TT_W     = 2**N_IN;
  localparam int                 CNT_W    = $clog2(TT_W) + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TT_W-1:0]   tt_q;
  // Only TT_W-1 bits need storing: the final bit goes straight to the table.
  logic [TT_W-2:0]   shadow_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_IN-1:0]   s1_idx_q;
  logic              s1_valid_q;
  logic              out_q;
  logic              out_valid_q;
  logic              cfg_done_q;

  logic              s2_adv;
  logic              in_ready;
  logic              in_fire;
  logic              load_last;

  // S1 may hand its index to S2 whenever S2 is empty or being emptied.
  assign s2_adv   = s1_valid_q & (~out_valid_q | bus.out_ready);
  // A reload request in the same cycle blocks new input so the drain
  // phase starts from a pipeline that is only shrinking.
  assign in_ready = (state_q == IDLE) & ~bus.cfg_start & (~s1_valid_q | s2_adv);
  assign in_fire  = bus.in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Reload FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    load_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The table may only change once no result still needs the old one.
        if (!s1_valid_q && !out_valid_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.cfg_valid && (cnt_q == LAST_CNT)) begin
          state_d   = IDLE;
          load_last = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline and table storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q        <= TT_INIT;
      shadow_q    <= '0;
      cnt_q       <= '0;
      s1_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_idx_q   <= bus.in_vec;
        s1_valid_q <= 1'b1;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_adv) begin
        out_q       <= tt_q[s1_idx_q];
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      cfg_done_q <= load_last;

      if ((state_q == LOAD) && bus.cfg_valid) begin
        shadow_q <= {shadow_q[TT_W-3:0], bus.cfg_bit};
        if (load_last) begin
          tt_q  <= {shadow_q, bus.cfg_bit};
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef CELLO_TT_EVAL_COUNT_EN
  // --------------------------------------------------------------------------
  // Saturating count of result handshakes; cleared as a new table goes live
  // --------------------------------------------------------------------------
  logic [15:0] eval_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_count_q <= '0;
    end else if (load_last) begin
      eval_count_q <= '0;
    end else if (out_valid_q && bus.out_ready && (eval_count_q != 16'hFFFF)) begin
      eval_count_q <= eval_count_q + 16'd1;
    end
  end

  assign eval_count = eval_count_q;
`else
  // Handshake counter not built in this configuration.
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/cello_tt_eval.md
Name: cello_tt_eval

Overview:
- Clocked, parametrised successor to the fixed 4-input NOR/NOT Cello logic designs.
- Evaluates an N-input Boolean function held in a reprogrammable truth-table register, with a default table of 0x599A.
- Input and output use valid/ready streams through a 2-stage pipeline.
- The table is reloaded at run time through a serial config port, so one instance covers any N_IN-input design and test benches can sweep functions without re-synthesis.

Parameters:
- N_IN, 4, number of logic inputs; table width TT_W = 2**N_IN (legal 2..8).
- TT_INIT, 16'h599A, truth table loaded at reset; width TT_W; bit i = output for input index i.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vec  in  N_IN  logic inputs; in_vec[N_IN-1] is the index MSB, in_vec[0] the LSB.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block accepts in_vec this cycle.
- out  out  1  evaluated function value.
- out_valid  out  1  out is valid.
- out_ready  in  1  consumer accepts out.
- cfg_start  in  1  request table reload (1-cycle pulse).
- cfg_bit  in  1  serial table bit, MSB (bit TT_W-1) first.
- cfg_valid  in  1  cfg_bit is valid.
- cfg_done  out  1  1-cycle pulse; new table is active.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release): active table = TT_INIT, shadow = 0, state IDLE, bit counter 0, stage valids 0. Outputs after reset: out=0, out_valid=0, cfg_done=0, busy=0.
- Reset asserted mid-load discards the partial load; the table stays TT_INIT.
- Pipeline:
  - S1 register holds the index; S2 register holds out/out_valid.
  - s2_adv = s1_valid & (!out_valid | out_ready).
  - in_ready = (state==IDLE) & !cfg_start & (!s1_valid | s2_adv).
  - Input handshake at edge k loads S1. Out becomes valid after edge k+1, i.e. latency 2 cycles. Throughput is 1 result per cycle while out_ready=1.
  - out = active_table[index] at the S2 load. out/out_valid are held stable while out_valid & !out_ready. No data loss or duplication under any backpressure pattern.
- FSM:
  - IDLE --cfg_start--> DRAIN.
  - DRAIN: in_ready=0; stays in DRAIN until s1_valid=0 and out_valid=0. Out continues to drain normally. Then --> LOAD.
  - LOAD: each cycle with cfg_valid=1 shifts cfg_bit into the shadow LSB and increments the counter. When the TT_W-th bit is accepted: active <= {shadow[TT_W-2:0], cfg_bit}, counter <= 0, cfg_done=1 on the next cycle, state --> IDLE.
- cfg_start and in_valid in the same IDLE cycle: cfg_start wins (in_ready=0).
- cfg_start is ignored outside IDLE. cfg_valid is ignored outside LOAD.
- cfg_valid gaps in LOAD are allowed; there is no timeout.
- Counter width is clog2(TT_W)+1. No wrap occurs because the exit happens exactly at count TT_W.

Optional Feature:
- Macro: CELLO_TT_EVAL_COUNT_EN.
- Defined:
  - Adds output port eval_count, 16 bits.
  - Increments on each out handshake (out_valid & out_ready) and saturates at 16'hFFFF.
  - Clears to 0 on reset and in the cycle cfg_done is asserted.
  - An out handshake in the cfg_done cycle cannot occur, because the pipeline is drained.
- Not defined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- Reset then default table, out_ready=1: in_vec=0,1,14,15 back-to-back -> out=0,1,1,0, each 2 cycles after acceptance, one result per cycle.
- Backpressure: out_ready=0 with 3 inputs offered -> in_ready drops after 2 accepted, out holds the first result stable. Release -> all 3 results emerge in order with no loss.
- Reload: cfg_start, then 16 bits of 16'hFFFF -> cfg_done pulses once, busy falls. in_vec=0 -> out=1; in_vec=9 -> out=1.
- Drain ordering: cfg_start while 2 results are in flight with out_ready=0 -> state stays DRAIN, busy=1. After out_ready=1 both old-table results emerge, then LOAD proceeds.
- Async reset during LOAD after 7 bits -> outputs reset immediately. in_vec=1 -> out=1 (TT_INIT restored). cfg_done never pulses.
- With CELLO_TT_EVAL_COUNT_EN: 5 handshakes -> eval_count=5. Reload -> 0 at cfg_done. Preload near 0xFFFF via long run -> count stays at 0xFFFF.
